// File: rtl/acc_out_fifo_pkg.sv
// acc_out_fifo_pkg: shared widths and default depth for the accumulator output path
package acc_out_fifo_pkg;
  localparam int ACC_WIDTH = 8;
  localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/acc_out_fifo_if.sv
// acc_out_fifo_if: accumulator capture inputs and sink handshake of the output FIFO
interface acc_out_fifo_if
  import acc_out_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = ACC_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
);
  logic [DATA_WIDTH-1:0] acc;
  logic acc_ce;
  logic ovf_clr;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  modport master (
    output acc, acc_ce, ovf_clr, out_ready,
    input out_data, out_valid, count, overflow
  );
  modport slave (
    input acc, acc_ce, ovf_clr, out_ready,
    output out_data, out_valid, count, overflow
  );
endinterface

// File: rtl/acc_out_fifo_sync_fifo.sv
// acc_out_fifo_sync_fifo: show-ahead synchronous FIFO that keeps the last popped word visible when empty
module acc_out_fifo_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] last_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic do_pop, do_push;
  assign empty_o = count_q == '0;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);
  assign dout_o = empty_o ? last_q : mem_q[rd_ptr_q];
  assign count_o = count_q;
  // storage: a push while full is only allowed when the head leaves in the same cycle
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  // pointers wrap modulo DEPTH; last_q keeps the popped head for the empty case
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/acc_out_fifo.sv
// acc_out_fifo: captures each accumulator write one cycle after acc_ce and queues it for a valid/ready sink
module acc_out_fifo
  import acc_out_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = ACC_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CHANGE_FILTER = 1
) (
  input logic clk,
  input logic rst,
  acc_out_fifo_if.slave bus
);
  logic [DATA_WIDTH-1:0] last_q;
  logic acc_ce_d_q, have_last_q, overflow_q, overflow_d;
  logic push_req, pop, drop, full, empty;
  assign push_req = acc_ce_d_q & (CHANGE_FILTER == 0 || !have_last_q || bus.acc != last_q);
  assign pop = !empty & bus.out_ready;
  assign drop = push_req & full & !pop;
  assign overflow_d = drop | (overflow_q & !bus.ovf_clr);
  assign bus.out_valid = !empty;
  assign bus.overflow = overflow_q;
  acc_out_fifo_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push_req),
    .pop_i(pop),
    .din_i(bus.acc),
    .dout_o(bus.out_data),
    .full_o(full),
    .empty_o(empty),
    .count_o(bus.count)
  );
  // acc is only valid the cycle after acc_ce, so delay the strobe; remember every requested value for the filter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_ce_d_q <= 1'b0;
      last_q <= '0;
      have_last_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      acc_ce_d_q <= bus.acc_ce;
      overflow_q <= overflow_d;
      if (push_req) begin
        last_q <= bus.acc;
        have_last_q <= 1'b1;
      end
    end
endmodule

// File: tb/tb_acc_out_fifo.sv
// tb_acc_out_fifo: directed checks of capture latency, filtering, overflow, full push/pop and async reset
module tb_acc_out_fifo;
  logic clk, rst;
  logic [7:0] acc;
  logic acc_ce, ovf_clr, out_ready;
  int errors = 0;
  int checks = 0;
  acc_out_fifo_if #(.DATA_WIDTH(8), .DEPTH(4)) a_if ();
  acc_out_fifo_if #(.DATA_WIDTH(8), .DEPTH(4)) b_if ();
  assign a_if.acc = acc;
  assign a_if.acc_ce = acc_ce;
  assign a_if.ovf_clr = ovf_clr;
  assign a_if.out_ready = out_ready;
  assign b_if.acc = acc;
  assign b_if.acc_ce = acc_ce;
  assign b_if.ovf_clr = ovf_clr;
  assign b_if.out_ready = out_ready;
  acc_out_fifo #(.DATA_WIDTH(8), .DEPTH(4), .CHANGE_FILTER(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  acc_out_fifo #(.DATA_WIDTH(8), .DEPTH(4), .CHANGE_FILTER(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    acc = 8'h00;
    acc_ce = 1'b0;
    ovf_clr = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask
  task automatic write_one(input logic [7:0] v);
    acc_ce = 1'b1;
    step();
    acc = v;
    acc_ce = 1'b0;
    step();
  endtask
  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", a_if.out_valid); end
    checks++; if (a_if.count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", a_if.count); end
    checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%0b exp=0", a_if.overflow); end
    checks++; if (a_if.out_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%0h exp=00", a_if.out_data); end
  endtask
  task automatic test_first_zero();
    do_reset();
    acc_ce = 1'b1;
    step();
    acc = 8'h00;
    acc_ce = 1'b0;
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid_t1 got=%0b exp=0", a_if.out_valid); end
    step();
    checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid_t2 got=%0b exp=1", a_if.out_valid); end
    checks++; if (a_if.out_data !== 8'h00) begin errors++; $display("FAIL zero_data got=%0h exp=00", a_if.out_data); end
    checks++; if (a_if.count !== 3'd1) begin errors++; $display("FAIL zero_count got=%0d exp=1", a_if.count); end
  endtask
  task automatic test_filter();
    do_reset();
    write_one(8'h05);
    write_one(8'h05);
    write_one(8'h07);
    checks++; if (a_if.count !== 3'd2) begin errors++; $display("FAIL filt_count_on got=%0d exp=2", a_if.count); end
    checks++; if (b_if.count !== 3'd3) begin errors++; $display("FAIL filt_count_off got=%0d exp=3", b_if.count); end
    checks++; if (a_if.out_data !== 8'h05) begin errors++; $display("FAIL filt_on_head0 got=%0h exp=05", a_if.out_data); end
    checks++; if (b_if.out_data !== 8'h05) begin errors++; $display("FAIL filt_off_head0 got=%0h exp=05", b_if.out_data); end
    pop_one();
    checks++; if (a_if.out_data !== 8'h07) begin errors++; $display("FAIL filt_on_head1 got=%0h exp=07", a_if.out_data); end
    checks++; if (b_if.out_data !== 8'h05) begin errors++; $display("FAIL filt_off_head1 got=%0h exp=05", b_if.out_data); end
    pop_one();
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL filt_on_empty got=%0b exp=0", a_if.out_valid); end
    checks++; if (a_if.out_data !== 8'h07) begin errors++; $display("FAIL filt_on_hold got=%0h exp=07", a_if.out_data); end
    checks++; if (b_if.out_data !== 8'h07 || b_if.count !== 3'd1) begin errors++; $display("FAIL filt_off_head2 got=%0h/%0d exp=07/1", b_if.out_data, b_if.count); end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) write_one(8'(i));
    checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got=%0b exp=0", a_if.overflow); end
    write_one(8'h05);
    write_one(8'h06);
    checks++; if (a_if.count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", a_if.count); end
    checks++; if (a_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", a_if.overflow); end
    acc_ce = 1'b1;
    step();
    acc = 8'h07;
    acc_ce = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++; if (a_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%0b exp=1", a_if.overflow); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (a_if.out_valid !== 1'b1 || a_if.out_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d got=%0b/%0h exp=1/%0h", i, a_if.out_valid, a_if.out_data, i); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (a_if.out_valid !== 1'b0 || a_if.out_data !== 8'h04) begin errors++; $display("FAIL ovf_empty got=%0b/%0h exp=0/04", a_if.out_valid, a_if.out_data); end
    checks++; if (a_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", a_if.overflow); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%0b exp=0", a_if.overflow); end
  endtask
  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) write_one(8'h10 + 8'(i));
    checks++; if (a_if.count !== 3'd4) begin errors++; $display("FAIL fpp_full got=%0d exp=4", a_if.count); end
    acc_ce = 1'b1;
    step();
    acc = 8'h14;
    acc_ce = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (a_if.count !== 3'd4) begin errors++; $display("FAIL fpp_count got=%0d exp=4", a_if.count); end
    checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got=%0b exp=0", a_if.overflow); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (a_if.out_valid !== 1'b1 || a_if.out_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL fpp_drain%0d got=%0b/%0h exp=1/%0h", i, a_if.out_valid, a_if.out_data, 8'h10 + 8'(i)); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got=%0b exp=0", a_if.out_valid); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] got [16];
    int n = 0;
    int maxc = 0;
    do_reset();
    out_ready = 1'b1;
    acc_ce = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i < 8) acc = 8'h20 + 8'(i);
      if (i == 7) acc_ce = 1'b0;
      if (int'(a_if.count) > maxc) maxc = int'(a_if.count);
      if (a_if.out_valid === 1'b1 && n < 16) begin
        got[n] = a_if.out_data;
        n++;
      end
    end
    out_ready = 1'b0;
    checks++; if (n !== 8) begin errors++; $display("FAIL b2b_n got=%0d exp=8", n); end
    for (int i = 0; i < 8 && i < n; i++) begin
      checks++; if (got[i] !== 8'h20 + 8'(i)) begin errors++; $display("FAIL b2b_data%0d got=%0h exp=%0h", i, got[i], 8'h20 + 8'(i)); end
    end
    checks++; if (maxc > 2) begin errors++; $display("FAIL b2b_maxcount got=%0d exp<=2", maxc); end
    checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got=%0b exp=0", a_if.overflow); end
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) write_one(8'h30 + 8'(i));
    pop_one();
    checks++; if (a_if.count !== 3'd3 || a_if.overflow !== 1'b1) begin errors++; $display("FAIL ar_pre got=%0d/%0b exp=3/1", a_if.count, a_if.overflow); end
    acc_ce = 1'b1;
    step();
    acc = 8'h55;
    acc_ce = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%0b exp=0", a_if.out_valid); end
    checks++; if (a_if.count !== 3'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", a_if.count); end
    checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL ar_overflow got=%0b exp=0", a_if.overflow); end
    step();
    rst = 1'b0;
    step();
    checks++; if (a_if.count !== 3'd0) begin errors++; $display("FAIL ar_pending got=%0d exp=0", a_if.count); end
    write_one(8'h09);
    checks++; if (a_if.count !== 3'd1 || a_if.out_data !== 8'h09) begin errors++; $display("FAIL ar_after got=%0d/%0h exp=1/09", a_if.count, a_if.out_data); end
    pop_one();
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL ar_alone got=%0b exp=0", a_if.out_valid); end
  endtask
  initial begin
    rst = 1'b1;
    acc = 8'h00;
    acc_ce = 1'b0;
    ovf_clr = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_first_zero();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
